// File: rtl/riscv_dmem_arbiter.sv
// Two-port LSU arbiter for the shared D-cache port.
// Optional build macro: RISCV_DMEM_ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps
module riscv_dmem_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int TAG_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      req0_addr,
  input  logic [31:0]      req0_wdata,
  input  logic             req0_rd,
  input  logic [3:0]       req0_wr,
  input  logic             req0_cacheable,
  input  logic             req0_invalidate,
  input  logic             req0_writeback,
  input  logic             req0_flush,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_accept,
  output logic             req0_ack,
  output logic             req0_error,
  output logic             req0_load_fault,
  output logic             req0_store_fault,
  output logic [31:0]      req0_rdata,
  output logic [TAG_W-1:0] req0_resp_tag,
  input  logic [31:0]      req1_addr,
  input  logic [31:0]      req1_wdata,
  input  logic             req1_rd,
  input  logic [3:0]       req1_wr,
  input  logic             req1_cacheable,
  input  logic             req1_invalidate,
  input  logic             req1_writeback,
  input  logic             req1_flush,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_accept,
  output logic             req1_ack,
  output logic             req1_error,
  output logic             req1_load_fault,
  output logic             req1_store_fault,
  output logic [31:0]      req1_rdata,
  output logic [TAG_W-1:0] req1_resp_tag,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_rd,
  output logic [3:0]       mem_wr,
  output logic             mem_cacheable,
  output logic             mem_invalidate,
  output logic             mem_writeback,
  output logic             mem_flush,
  output logic [TAG_W-1:0] mem_req_tag,
  input  logic             mem_accept,
  input  logic             mem_ack,
  input  logic             mem_error,
  input  logic             mem_load_fault,
  input  logic             mem_store_fault,
  input  logic [31:0]      mem_rdata,
  input  logic [TAG_W-1:0] mem_resp_tag,
  output logic             spurious_ack
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(OUTSTANDING - 1);

  typedef enum logic {
    ST_OPEN,
    ST_LOCK
  } lock_e;

  lock_e lock_q, lock_d;
  logic  grant_q, grant_d;
  logic  spur_q, spur_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [OUTSTANDING-1:0] fifo_q, fifo_d;
`ifndef RISCV_DMEM_ARB_FIXED_PRIO_EN
  logic last_q, last_d;
`endif

  logic live;
  logic act0, act1;
  logic full, empty;
  logic sel, gnt_vld, gnt_id;
  logic fwd, acc, pop, head_id;

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Requester activity, round-robin or fixed pick, lock override
  always_comb begin
    live = ~rst_n;
    act0 = req0_rd | (|req0_wr) | req0_invalidate
         | req0_writeback | req0_flush;
    act1 = req1_rd | (|req1_wr) | req1_invalidate
         | req1_writeback | req1_flush;
    full  = (cnt_q == CNT_MAX);
    empty = (cnt_q == '0);
`ifdef RISCV_DMEM_ARB_FIXED_PRIO_EN
    sel = ~act0;
`else
    if (act0 && act1) sel = ~last_q;
    else              sel = act1;
`endif
    gnt_vld = (lock_q == ST_LOCK) | act0 | act1;
    gnt_id  = (lock_q == ST_LOCK) ? grant_q : sel;
    fwd     = live & gnt_vld & ~full;
    acc     = fwd & mem_accept;
    pop     = live & mem_ack & ~empty;
    head_id = fifo_q[rptr_q];
  end

  // Lock holds the grant while memory back-pressures
  always_comb begin
    lock_d  = lock_q;
    grant_d = grant_q;
    unique case (lock_q)
      ST_OPEN: begin
        if (fwd && !mem_accept) begin
          lock_d  = ST_LOCK;
          grant_d = gnt_id;
        end
      end
      ST_LOCK: begin
        if (acc) lock_d = ST_OPEN;
      end
      default: lock_d = ST_OPEN;
    endcase
  end

  // In-order ID FIFO bookkeeping and sticky spurious flag
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    spur_d = spur_q | (live & mem_ack & empty);
    if (acc) begin
      fifo_d[wptr_q] = gnt_id;
      wptr_d = inc(wptr_q);
    end
    if (pop) rptr_d = inc(rptr_q);
    unique case ({acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

`ifndef RISCV_DMEM_ARB_FIXED_PRIO_EN
  // Remember the last accepted requester for fairness
  always_comb begin
    last_d = last_q;
    if (acc) last_d = gnt_id;
  end
`endif

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      lock_q  <= ST_OPEN;
      grant_q <= 1'b0;
      spur_q  <= 1'b0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fifo_q  <= '0;
`ifndef RISCV_DMEM_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      lock_q  <= lock_d;
      grant_q <= grant_d;
      spur_q  <= spur_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fifo_q  <= fifo_d;
`ifndef RISCV_DMEM_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // Forward the granted request; strobes quiet when not presented
  always_comb begin
    mem_addr      = req0_addr;
    mem_wdata     = req0_wdata;
    mem_req_tag   = req0_tag;
    mem_cacheable = req0_cacheable;
    mem_rd        = 1'b0;
    mem_wr        = 4'h0;
    mem_invalidate = 1'b0;
    mem_writeback = 1'b0;
    mem_flush     = 1'b0;
    if (fwd) begin
      if (gnt_id) begin
        mem_addr       = req1_addr;
        mem_wdata      = req1_wdata;
        mem_req_tag    = req1_tag;
        mem_cacheable  = req1_cacheable;
        mem_rd         = req1_rd;
        mem_wr         = req1_wr;
        mem_invalidate = req1_invalidate;
        mem_writeback  = req1_writeback;
        mem_flush      = req1_flush;
      end else begin
        mem_rd         = req0_rd;
        mem_wr         = req0_wr;
        mem_invalidate = req0_invalidate;
        mem_writeback  = req0_writeback;
        mem_flush      = req0_flush;
      end
    end
  end

  // Accepts and FIFO-head routed responses
  always_comb begin
    req0_accept      = acc & ~gnt_id;
    req1_accept      = acc & gnt_id;
    req0_ack         = pop & ~head_id;
    req1_ack         = pop & head_id;
    req0_error       = req0_ack & mem_error;
    req1_error       = req1_ack & mem_error;
    req0_load_fault  = req0_ack & mem_load_fault;
    req1_load_fault  = req1_ack & mem_load_fault;
    req0_store_fault = req0_ack & mem_store_fault;
    req1_store_fault = req1_ack & mem_store_fault;
    req0_rdata       = mem_rdata;
    req1_rdata       = mem_rdata;
    req0_resp_tag    = mem_resp_tag;
    req1_resp_tag    = mem_resp_tag;
    spurious_ack     = spur_q;
  end

endmodule
